// File: rtl/fetch_pkg.sv
// rtl/fetch_pkg.sv - shared types and constants for the instruction-fetch unit
package fetch_pkg;

  localparam int INSTR_W   = 32;
  localparam int PC_STEP   = 4;
  localparam int SLOT_XLEN = 32;

  typedef enum logic {
    RUN  = 1'b0,
    HALT = 1'b1
  } fetch_state_t;

  typedef struct packed {
    logic [SLOT_XLEN-1:0] pc;
    logic [INSTR_W-1:0]   data;
    logic                 filled;
  } slot_t;

endpackage

// File: rtl/fetch_slot_buffer.sv
// rtl/fetch_slot_buffer.sv - in-order slot buffer pairing fetched words with their PCs
module fetch_slot_buffer
  import fetch_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int DEPTH = 4,
  localparam int PW   = $clog2(DEPTH),
  localparam int CW   = PW + 1
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               flush,
  input  logic               alloc,
  input  logic [XLEN-1:0]    alloc_pc,
  input  logic               fill,
  input  logic [INSTR_W-1:0] fill_data,
  input  logic               pop,
  output logic               head_filled,
  output logic [INSTR_W-1:0] head_data,
  output logic [XLEN-1:0]    head_pc,
  output logic [CW-1:0]      alloc_count,
  output logic [CW-1:0]      unfilled_count
);

  logic [XLEN-1:0]    pc_q   [DEPTH];
  logic [INSTR_W-1:0] data_q [DEPTH];
  logic [DEPTH-1:0]   filled_q;
  logic [PW-1:0]      wr_ptr, fill_ptr, rd_ptr;
  logic [CW-1:0]      fill_count;
  logic [DEPTH-1:0]   set_mask, clr_mask;

  assign set_mask = fill ? (DEPTH'(1) << fill_ptr) : '0;
  assign clr_mask = pop  ? (DEPTH'(1) << rd_ptr)   : '0;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr      <= '0;
      fill_ptr    <= '0;
      rd_ptr      <= '0;
      filled_q    <= '0;
      alloc_count <= '0;
      fill_count  <= '0;
    end else if (flush) begin
      wr_ptr      <= '0;
      fill_ptr    <= '0;
      rd_ptr      <= '0;
      filled_q    <= '0;
      alloc_count <= '0;
      fill_count  <= '0;
    end else begin
      if (alloc) wr_ptr <= wr_ptr + 1'b1;
      if (fill)  fill_ptr <= fill_ptr + 1'b1;
      if (pop)   rd_ptr <= rd_ptr + 1'b1;
      filled_q    <= (filled_q | set_mask) & ~clr_mask;
      alloc_count <= alloc_count + CW'(alloc) - CW'(pop);
      fill_count  <= fill_count + CW'(fill) - CW'(pop);
    end
  end

  // Payload storage needs no reset: a slot is only read once its filled bit is set.
  always_ff @(posedge clk) begin
    if (alloc && !flush) pc_q[wr_ptr] <= alloc_pc;
    if (fill && !flush)  data_q[fill_ptr] <= fill_data;
  end

  assign head_filled    = filled_q[rd_ptr] && (alloc_count != '0);
  assign head_data      = data_q[rd_ptr];
  assign head_pc        = pc_q[rd_ptr];
  assign unfilled_count = alloc_count - fill_count;

endmodule

// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - PC generation, request issue, redirect/flush and misalign halt
module fetch_unit
  import fetch_pkg::*;
#(
  parameter int              XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = '0,
  parameter int              DEPTH    = 4
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               redirect_valid,
  input  logic [XLEN-1:0]    redirect_pc,
  output logic               imem_req_valid,
  input  logic               imem_req_ready,
  output logic [XLEN-1:0]    imem_req_addr,
  input  logic               imem_rsp_valid,
  input  logic [INSTR_W-1:0] imem_rsp_data,
  output logic               inst_valid,
  input  logic               inst_ready,
  output logic [INSTR_W-1:0] inst_data,
  output logic [XLEN-1:0]    inst_pc,
  output logic               misalign_err
);

  localparam int CW = $clog2(DEPTH) + 1;

  fetch_state_t    state;
  logic [XLEN-1:0] pc;
  logic [CW-1:0]   drop_cnt, alloc_count, unfilled_count;
  logic [CW:0]     in_use;
  logic            req_fire, rsp_fill, head_filled, pop;

  // Dropped-but-still-in-flight responses occupy buffer budget until they return.
  assign in_use         = {1'b0, alloc_count} + {1'b0, drop_cnt};
  assign imem_req_valid = reset_n && (state == RUN) && !redirect_valid
                          && (in_use < (CW+1)'(DEPTH));
  assign imem_req_addr  = pc;
  assign req_fire       = imem_req_valid && imem_req_ready;
  assign rsp_fill       = imem_rsp_valid && !redirect_valid && (drop_cnt == '0);
  assign inst_valid     = head_filled && !redirect_valid;
  assign pop            = inst_valid && inst_ready;
  assign misalign_err   = (state == HALT);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= RUN;
      pc       <= RESET_PC;
      drop_cnt <= '0;
    end else if (redirect_valid) begin
      pc       <= {redirect_pc[XLEN-1:2], 2'b00};
      state    <= (redirect_pc[1:0] != 2'b00) ? HALT : RUN;
      drop_cnt <= drop_cnt + unfilled_count - CW'(imem_rsp_valid);
    end else begin
      if (req_fire) pc <= pc + XLEN'(PC_STEP);
      if (imem_rsp_valid && (drop_cnt != '0)) drop_cnt <= drop_cnt - 1'b1;
    end
  end

  fetch_slot_buffer #(
    .XLEN  (XLEN),
    .DEPTH (DEPTH)
  ) u_slots (
    .clk            (clk),
    .reset_n        (reset_n),
    .flush          (redirect_valid),
    .alloc          (req_fire),
    .alloc_pc       (pc),
    .fill           (rsp_fill),
    .fill_data      (imem_rsp_data),
    .pop            (pop),
    .head_filled    (head_filled),
    .head_data      (inst_data),
    .head_pc        (inst_pc),
    .alloc_count    (alloc_count),
    .unfilled_count (unfilled_count)
  );

  always @(posedge clk) begin
    if (reset_n) begin
      assert (in_use <= (CW+1)'(DEPTH));
      assert (!imem_rsp_valid || (drop_cnt != '0) || (unfilled_count != '0));
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// tb/tb_fetch_unit.sv - randomized self-checking bench for fetch_unit with a queue-based reference
module tb_fetch_unit;

  localparam int          DEPTH = 4;
  localparam logic [31:0] RPC   = 32'hFFFF_FFF8;

  logic        clk = 1'b0, reset_n = 1'b0;
  logic        redirect_valid = 1'b0, imem_req_ready = 1'b0, imem_rsp_valid = 1'b0, inst_ready = 1'b0;
  logic [31:0] redirect_pc = '0, imem_rsp_data = '0;
  logic        imem_req_valid, inst_valid, misalign_err;
  logic [31:0] imem_req_addr, inst_data, inst_pc;

  fetch_unit #(.XLEN(32), .RESET_PC(RPC), .DEPTH(DEPTH)) dut (
    .clk(clk), .reset_n(reset_n),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready), .imem_req_addr(imem_req_addr),
    .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
    .inst_valid(inst_valid), .inst_ready(inst_ready), .inst_data(inst_data), .inst_pc(inst_pc),
    .misalign_err(misalign_err)
  );

  always #5 clk = ~clk;

  typedef struct { logic [31:0] addr; int due; int ep; } mreq_t;
  typedef struct { logic [31:0] pc; bit filled; } exp_t;

  mreq_t       mq[$];
  exp_t        eq[$];
  int          cyc, epoch, rsp_ep, last_due, n_req, n_pop;
  int          lat_min = 1, lat_max = 1, rsp_pct = 100;
  logic [31:0] exp_pc, last_pop_pc;
  bit          exp_halt;
  int          checks = 0, failures = 0;

  function automatic logic [31:0] word_of(logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'hC0DE_0000 ^ {a[15:0], a[31:16]};
  endfunction

  // One clock of the reference: check outputs, advance model, then drive memory for next cycle.
  task automatic tick();
    int  stale, lat, due;
    bit  exp_req, exp_inst, done;
    #1;
    stale = 0;
    foreach (mq[i]) if (mq[i].ep != epoch) stale++;
    if (imem_rsp_valid && rsp_ep != epoch) stale++;
    exp_req  = !exp_halt && !redirect_valid && (eq.size() + stale < DEPTH);
    exp_inst = !redirect_valid && eq.size() > 0 && eq[0].filled;
    checks++;
    if (imem_req_valid !== exp_req) begin
      failures++; $display("FAIL req_valid cyc=%0d got=%b exp=%b", cyc, imem_req_valid, exp_req);
    end
    checks++;
    if (misalign_err !== exp_halt) begin
      failures++; $display("FAIL misalign_err cyc=%0d got=%b exp=%b", cyc, misalign_err, exp_halt);
    end
    checks++;
    if (inst_valid !== exp_inst) begin
      failures++; $display("FAIL inst_valid cyc=%0d got=%b exp=%b", cyc, inst_valid, exp_inst);
    end
    if (imem_req_valid && exp_req) begin
      checks++;
      if (imem_req_addr !== exp_pc) begin
        failures++; $display("FAIL req_addr cyc=%0d got=%h exp=%h", cyc, imem_req_addr, exp_pc);
      end
    end
    if (inst_valid && exp_inst) begin
      checks++;
      if (inst_pc !== eq[0].pc) begin
        failures++; $display("FAIL inst_pc cyc=%0d got=%h exp=%h", cyc, inst_pc, eq[0].pc);
      end
      checks++;
      if (inst_data !== word_of(eq[0].pc)) begin
        failures++; $display("FAIL inst_data cyc=%0d got=%h exp=%h", cyc, inst_data, word_of(eq[0].pc));
      end
    end
    if (redirect_valid) begin
      epoch++;
      eq.delete();
      exp_pc   = {redirect_pc[31:2], 2'b00};
      exp_halt = (redirect_pc[1:0] != 2'b00);
    end else begin
      done = 0;
      if (imem_rsp_valid && rsp_ep == epoch)
        foreach (eq[i]) if (!done && !eq[i].filled) begin eq[i].filled = 1; done = 1; end
      if (inst_valid && inst_ready && eq.size() > 0) begin
        last_pop_pc = eq[0].pc; eq.delete(0); n_pop++;
      end
      if (imem_req_valid && imem_req_ready) begin
        eq.push_back('{pc: exp_pc, filled: 1'b0});
        exp_pc = exp_pc + 32'd4;
        lat = $urandom_range(lat_max, lat_min);
        due = cyc + lat;
        if (due < last_due) due = last_due;
        last_due = due;
        mq.push_back('{addr: imem_req_addr, due: due, ep: epoch});
        n_req++;
      end
    end
    @(posedge clk);
    cyc++;
    @(negedge clk);
    if (mq.size() > 0 && mq[0].due <= cyc && $urandom_range(99) < rsp_pct) begin
      imem_rsp_valid = 1'b1; imem_rsp_data = word_of(mq[0].addr); rsp_ep = mq[0].ep; mq.delete(0);
    end else begin
      imem_rsp_valid = 1'b0;
    end
  endtask

  task automatic apply_reset();
    reset_n = 1'b0; redirect_valid = 1'b0; imem_rsp_valid = 1'b0;
    mq.delete(); eq.delete();
    exp_pc = RPC; exp_halt = 0; last_due = 0; epoch++;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  task automatic do_redirect(input logic [31:0] target);
    redirect_valid = 1'b1; redirect_pc = target;
    tick();
    redirect_valid = 1'b0;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    #3;
    checks++;
    if (imem_req_valid !== 1'b0 || inst_valid !== 1'b0 || misalign_err !== 1'b0) begin
      failures++; $display("FAIL reset_outputs got=%b%b%b exp=000", imem_req_valid, inst_valid, misalign_err);
    end
    apply_reset();
    #1;
    checks++;
    if (imem_req_valid !== 1'b1 || imem_req_addr !== RPC) begin
      failures++; $display("FAIL reset_first_req got=%b/%h exp=1/%h", imem_req_valid, imem_req_addr, RPC);
    end
  endtask

  task automatic test_stream();
    imem_req_ready = 1'b1; inst_ready = 1'b1; lat_min = 1; lat_max = 1; rsp_pct = 100;
    n_pop = 0;
    repeat (12) tick();
    checks++;
    if (n_pop != 10) begin failures++; $display("FAIL stream_pops got=%0d exp=10", n_pop); end
    checks++;
    if (last_pop_pc !== 32'h0000_001C) begin
      failures++; $display("FAIL stream_wrap_pc got=%h exp=0000001c", last_pop_pc);
    end
  endtask

  task automatic test_backpressure();
    do_redirect(32'h0);
    inst_ready = 1'b0; n_req = 0;
    repeat (10) tick();
    #1;
    checks++;
    if (n_req != DEPTH) begin failures++; $display("FAIL bp_requests got=%0d exp=%0d", n_req, DEPTH); end
    checks++;
    if (imem_req_valid !== 1'b0 || inst_pc !== 32'h0 || inst_data !== word_of(32'h0)) begin
      failures++; $display("FAIL bp_hold got=%b/%h/%h exp=0/0/%h", imem_req_valid, inst_pc, inst_data, word_of(32'h0));
    end
    inst_ready = 1'b1;
    tick();
    #1;
    checks++;
    if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h10) begin
      failures++; $display("FAIL bp_resume got=%b/%h exp=1/00000010", imem_req_valid, imem_req_addr);
    end
    repeat (6) tick();
  endtask

  task automatic test_redirect_inflight();
    bit seen = 0;
    lat_min = 3; lat_max = 3;
    repeat (4) tick();
    do_redirect(32'h100);
    for (int i = 0; i < 20 && !seen; i++) begin
      #1;
      if (inst_valid) begin
        seen = 1;
        checks++;
        if (inst_pc !== 32'h100 || inst_data !== word_of(32'h100)) begin
          failures++; $display("FAIL redir_first got=%h/%h exp=00000100/%h", inst_pc, inst_data, word_of(32'h100));
        end
      end
      tick();
    end
    if (!seen) begin checks++; failures++; $display("FAIL redir_timeout got=none exp=inst_valid"); end
    repeat (4) tick();
  endtask

  task automatic test_redirect_collision();
    bit hit = 0;
    lat_min = 1; lat_max = 1; inst_ready = 1'b1;
    for (int i = 0; i < 20 && !hit; i++) begin
      if (imem_rsp_valid) hit = 1; else tick();
    end
    checks++;
    if (!hit) begin failures++; $display("FAIL collide_timeout got=no_rsp exp=rsp"); end
    redirect_valid = 1'b1; redirect_pc = 32'h340;
    #1;
    checks++;
    if (inst_valid !== 1'b0) begin failures++; $display("FAIL collide_inst_valid got=%b exp=0", inst_valid); end
    tick();
    redirect_valid = 1'b0;
    #1;
    checks++;
    if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h340) begin
      failures++; $display("FAIL collide_next_req got=%b/%h exp=1/00000340", imem_req_valid, imem_req_addr);
    end
    repeat (6) tick();
  endtask

  task automatic test_misalign();
    do_redirect(32'h102);
    for (int i = 0; i < 8; i++) begin
      #1;
      checks++;
      if (misalign_err !== 1'b1 || imem_req_valid !== 1'b0) begin
        failures++; $display("FAIL halt_hold got=%b/%b exp=1/0", misalign_err, imem_req_valid);
      end
      tick();
    end
    do_redirect(32'h200);
    #1;
    checks++;
    if (misalign_err !== 1'b0 || imem_req_valid !== 1'b1 || imem_req_addr !== 32'h200) begin
      failures++; $display("FAIL halt_exit got=%b/%b/%h exp=0/1/00000200", misalign_err, imem_req_valid, imem_req_addr);
    end
    repeat (8) tick();
  endtask

  task automatic test_random();
    lat_min = 1; lat_max = 4; rsp_pct = 70;
    for (int i = 0; i < 1500; i++) begin
      imem_req_ready = ($urandom_range(99) < 75);
      inst_ready     = ($urandom_range(99) < 65);
      if ($urandom_range(99) < 3) begin
        redirect_valid = 1'b1;
        redirect_pc    = {$urandom_range(32'h0FFF, 0), 2'b00} | (($urandom_range(7) == 0) ? 32'h2 : 32'h0);
      end else begin
        redirect_valid = 1'b0;
      end
      tick();
    end
    redirect_valid = 1'b0;
  endtask

  task automatic test_async_reset();
    lat_min = 1; lat_max = 1; rsp_pct = 100; imem_req_ready = 1'b1; inst_ready = 1'b0;
    do_redirect(32'h40);
    repeat (10) tick();
    #2;
    checks++;
    if (inst_valid !== 1'b1 || imem_req_valid !== 1'b0) begin
      failures++; $display("FAIL pre_reset_full got=%b/%b exp=1/0", inst_valid, imem_req_valid);
    end
    reset_n = 1'b0;
    #1;
    checks++;
    if (imem_req_valid !== 1'b0 || inst_valid !== 1'b0 || misalign_err !== 1'b0) begin
      failures++; $display("FAIL async_reset got=%b%b%b exp=000", imem_req_valid, inst_valid, misalign_err);
    end
    apply_reset();
    inst_ready = 1'b1;
    n_pop = 0;
    repeat (8) tick();
    checks++;
    if (n_pop != 6) begin failures++; $display("FAIL post_reset_pops got=%0d exp=6", n_pop); end
  endtask

  initial begin
    test_reset();
    test_stream();
    test_backpressure();
    test_redirect_inflight();
    test_redirect_collision();
    test_misalign();
    test_random();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Parametrised instruction-fetch unit. Generates the PC stream and issues in-order requests to instruction memory over a valid/ready request channel.
- Holds fetched instructions with their PCs in a DEPTH-entry slot buffer and hands them to decode over a valid/ready channel.
- Handles redirects from execute (branch/jump) with a single-cycle flush. Responses still in flight at a redirect are dropped.
- Sits between the PC/branch-resolution logic and the decode stage; it is the next generation of the team's fetch stage.

Parameters:
XLEN, 32, address/PC width
RESET_PC, 32'h0000_0000, PC fetched first after reset (XLEN wide)
DEPTH, 4, slot-buffer entries; power of two, >= 2

Ports:
clk  in  1  clock, all state on rising edge
reset_n  in  1  asynchronous active-low reset
redirect_valid  in  1  redirect PC this cycle, highest priority
redirect_pc  in  XLEN  redirect target
imem_req_valid  out  1  fetch request valid
imem_req_ready  in  1  memory accepts request
imem_req_addr  out  XLEN  fetch address (current PC)
imem_rsp_valid  in  1  instruction word returned, in request order, no backpressure
imem_rsp_data  in  32  instruction word
inst_valid  out  1  instruction available to decode
inst_ready  in  1  decode accepts instruction
inst_data  out  32  instruction word
inst_pc  out  XLEN  PC of inst_data
misalign_err  out  1  high while halted on a misaligned redirect target

Behaviour:
- Reset (async, while reset_n low):
  - pc = RESET_PC; wr/fill/rd pointers = 0; all filled bits = 0; alloc_count = 0; drop_cnt = 0; state = RUN.
  - Outputs imem_req_valid = 0, inst_valid = 0, misalign_err = 0.
  - Reset asserted mid-operation discards all slots and in-flight requests; the memory side must also reset.
- FSM states:
  - RUN: normal fetch.
  - HALT: no requests issued, misalign_err = 1.
  - RUN -> HALT on redirect_valid with redirect_pc[1:0] != 0.
  - HALT -> RUN on redirect_valid with an aligned redirect_pc.
  - Any redirect performs the full flush below.
- Request issue:
  - imem_req_valid = (state == RUN) && !redirect_valid && (alloc_count + drop_cnt < DEPTH).
  - imem_req_addr = pc.
  - On handshake: allocate slot[wr_ptr] = {pc, filled = 0}; wr_ptr++; alloc_count++; pc <= pc + 4, wrapping modulo 2^XLEN.
- Response:
  - If drop_cnt > 0: discard the word, drop_cnt--.
  - Otherwise: slot[fill_ptr].data = imem_rsp_data, filled = 1, fill_ptr++.
  - Memory latency is at least 1 cycle after request acceptance.
  - imem_rsp_valid with no outstanding request is illegal; assert it in simulation.
- Output:
  - inst_valid = slot[rd_ptr].filled && alloc_count != 0 && !redirect_valid.
  - inst_data and inst_pc come from slot[rd_ptr].
  - On inst_valid && inst_ready: clear filled, rd_ptr++, alloc_count--.
  - Hold inst_data and inst_pc stable while inst_valid && !inst_ready.
- Redirect (redirect_valid = 1):
  - pc <= {redirect_pc[XLEN-1:2], 2'b00}.
  - All slots invalidated; pointers reset to 0; alloc_count = 0.
  - drop_cnt <= drop_cnt + unfilled_allocated − (imem_rsp_valid ? 1 : 0). A response arriving in the redirect cycle is always discarded.
  - No request is issued and no pop occurs in the redirect cycle. Fetch at the new PC begins the following cycle.
- Simultaneous events in one cycle:
  - Request handshake, response fill and pop are independent; alloc_count net change = +req − pop.
  - Full buffer (alloc_count == DEPTH): imem_req_valid = 0 and pc holds.
  - Empty buffer, or head slot not yet filled: inst_valid = 0.
- Widths:
  - Pointers are $clog2(DEPTH) bits and wrap naturally.
  - alloc_count and drop_cnt are $clog2(DEPTH)+1 bits.
  - alloc_count + drop_cnt <= DEPTH always; assert it.

Decomposition:
- Package fetch_pkg:
  - typedef fetch_state_t {RUN, HALT}.
  - typedef slot_t {pc, data, filled}, width from XLEN.
  - Constant INSTR_W = 32.
  - Constant PC_STEP = 4.
- Sub-module fetch_slot_buffer (slot array, allocate/fill/pop pointers, counters, flush).
- fetch_unit keeps the PC, FSM, drop counter and request/redirect logic.

Test Plan:
- Reset release, imem_req_ready = 1, 1-cycle response, inst_ready = 1 -> requests at 0x0, 0x4, 0x8…; inst_pc/inst_data pairs match in order, one per cycle after a 2-cycle fill.
- inst_ready = 0 for 10 cycles, DEPTH = 4 -> exactly 4 requests accepted, then imem_req_valid = 0 and pc = 0x10; inst_data held stable; releasing inst_ready drains 0x0..0xC, then fetching resumes at 0x10.
- Redirect to 0x100 with 2 responses in flight, 3-cycle memory latency -> the next 2 responses are discarded; first inst_pc out = 0x100 with its own data; no stale PC ever visible.
- Redirect in the same cycle as imem_rsp_valid and inst_ready -> that response is dropped; inst_valid = 0 that cycle; next request address = redirect target.
- Redirect to 0x102 -> misalign_err = 1, imem_req_valid = 0 indefinitely; later redirect to 0x200 -> misalign_err = 0 next cycle and fetch resumes at 0x200.
- RESET_PC = 0xFFFF_FFF8, XLEN = 32 -> requests at 0xFFFF_FFF8, 0xFFFF_FFFC, 0x0000_0000 (wrap); async reset asserted mid-burst -> outputs go to reset values immediately, without waiting for a clock edge.
